issue_arbiter: RTL

ISSUE_ARBITER -- requirements
Module: issue_arbiter

---
 rtl/issue_arbiter_pkg.sv | 49 ++++
 rtl/issue_arbiter_fu_occupancy.sv | 52 +++++
 rtl/issue_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/issue_arbiter_pkg.sv
// Shared issue-stage types: FU index map, request classes, RS bundles.
// Also holds the default multiplier latency used by the arbiter.
package issue_arbiter_pkg;

    localparam logic [2:0] FU_ALU0   = 3'd0;
    localparam logic [2:0] FU_ALU1   = 3'd1;
    localparam logic [2:0] FU_BRANCH = 3'd2;
    localparam logic [2:0] FU_MEM    = 3'd3;
    localparam logic [2:0] FU_MULT   = 3'd4;

    localparam int FU_COUNT         = 5;
    localparam int MULT_LATENCY_DEF = 4;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_MEM    = 2'b10,
        CLS_MULT   = 2'b11
    } fu_class_e;

    typedef struct packed {
        logic       valid;
        fu_class_e  cls;
        logic [5:0] rob_tag;
        logic [5:0] src1_tag;
        logic [5:0] src2_tag;
        logic [5:0] dst_tag;
    } rs_entry_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] fu_idx;
        logic [5:0] rob_tag;
        logic [5:0] dst_tag;
    } rs_fu_packet_t;

    function automatic logic [2:0] class_to_fu(input fu_class_e cls);
        logic [2:0] fu;
        fu = FU_ALU0;
        unique case (cls)
            CLS_ALU:    fu = FU_ALU0;
            CLS_BRANCH: fu = FU_BRANCH;
            CLS_MEM:    fu = FU_MEM;
            CLS_MULT:   fu = FU_MULT;
        endcase
        return fu;
    endfunction

endpackage

// File: rtl/issue_arbiter_fu_occupancy.sv
// Occupancy tracking for the multi-cycle units (MULT counter, MEM busy).
// fu_ready_o is decoded purely from these registers.
module fu_occupancy
    import issue_arbiter_pkg::*;
#(
    parameter int FU_NUMBER    = FU_COUNT,
    parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 mult_start_i,
    input  logic                 mem_start_i,
    input  logic                 mem_done_i,
    output logic [FU_NUMBER-1:0] fu_ready_o
);

    // Counter holds the busy cycles still ahead, so a grant at edge E
    // frees the unit for a request MULT_LATENCY cycles later.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_LATENCY - 1);

    logic [3:0] mult_cnt;
    logic       mem_busy;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            mult_cnt <= 4'd0;
        end else if (mult_start_i) begin
            mult_cnt <= MULT_LOAD;
        end else if (mult_cnt != 4'd0) begin
            mult_cnt <= mult_cnt - 4'd1;
        end
    end

    // Start wins over done: done is only meaningful while busy.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            mem_busy <= 1'b0;
        end else if (mem_start_i) begin
            mem_busy <= 1'b1;
        end else if (mem_done_i) begin
            mem_busy <= 1'b0;
        end
    end

    always_comb begin
        fu_ready_o          = '1;
        fu_ready_o[FU_MEM]  = !mem_busy;
        fu_ready_o[FU_MULT] = (mult_cnt == 4'd0);
    end

endmodule

// File: rtl/issue_arbiter.sv
// Issue-port to functional-unit arbiter with round-robin ALU selection.
// Grants and FU start pulses are registered; readiness comes from fu_occupancy.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int SUPERSCALE_WIDTH = 2,
    parameter int FU_NUMBER        = FU_COUNT,
    parameter int MULT_LATENCY     = MULT_LATENCY_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic [SUPERSCALE_WIDTH-1:0]       req_valid_i,
    input  logic [SUPERSCALE_WIDTH-1:0][1:0]  req_class_i,
    input  logic [FU_NUMBER-1:0]              fu_done_i,
    output logic [SUPERSCALE_WIDTH-1:0]       grant_o,
    output logic [SUPERSCALE_WIDTH-1:0][2:0]  grant_fu_o,
    output logic [FU_NUMBER-1:0]              fu_start_o,
    output logic [FU_NUMBER-1:0]              fu_port_sel_o,
    output logic [FU_NUMBER-1:0]              fu_ready_o
);

    logic                             rr_ptr;
    logic [SUPERSCALE_WIDTH-1:0]      grant_d;
    logic [SUPERSCALE_WIDTH-1:0][2:0] grant_fu_d;
    logic [FU_NUMBER-1:0]             start_d;
    logic [FU_NUMBER-1:0]             sel_d;
    logic [FU_NUMBER-1:0]             avail;
    logic [1:0]                       alu_taken;
    logic [2:0]                       fu;
    logic                             hit;
    logic                             alu_grant;
    logic                             unused_done;

    assign unused_done = ^{fu_done_i[FU_NUMBER-1:FU_MEM+1],
                           fu_done_i[FU_MEM-1:0]};

    fu_occupancy #(
        .FU_NUMBER    (FU_NUMBER),
        .MULT_LATENCY (MULT_LATENCY)
    ) u_occ (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .mult_start_i (start_d[FU_MULT]),
        .mem_start_i  (start_d[FU_MEM]),
        .mem_done_i   (fu_done_i[FU_MEM]),
        .fu_ready_o   (fu_ready_o)
    );

    // Lower port index has priority; the first ALU request takes
    // ALU[rr_ptr], the second takes the other ALU.
    always_comb begin
        grant_d    = '0;
        grant_fu_d = '0;
        start_d    = '0;
        sel_d      = '0;
        avail      = fu_ready_o;
        alu_taken  = 2'b00;
        fu         = FU_ALU0;
        hit        = 1'b0;
        if (!flush_i) begin
            for (int p = 0; p < SUPERSCALE_WIDTH; p++) begin
                fu  = FU_ALU0;
                hit = 1'b0;
                if (req_valid_i[p]) begin
                    if (fu_class_e'(req_class_i[p]) == CLS_ALU) begin
                        if (!alu_taken[0]) begin
                            fu           = rr_ptr ? FU_ALU1 : FU_ALU0;
                            alu_taken[0] = 1'b1;
                            hit          = 1'b1;
                        end else if (!alu_taken[1]) begin
                            fu           = rr_ptr ? FU_ALU0 : FU_ALU1;
                            alu_taken[1] = 1'b1;
                            hit          = 1'b1;
                        end
                    end else begin
                        fu  = class_to_fu(fu_class_e'(req_class_i[p]));
                        hit = avail[fu];
                    end
                end
                if (hit) begin
                    avail[fu]     = 1'b0;
                    grant_d[p]    = 1'b1;
                    grant_fu_d[p] = fu;
                    start_d[fu]   = 1'b1;
                    sel_d[fu]     = p[0];
                end
            end
        end
    end

    assign alu_grant = start_d[FU_ALU0] | start_d[FU_ALU1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (alu_grant) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_o       <= '0;
            grant_fu_o    <= '0;
            fu_start_o    <= '0;
            fu_port_sel_o <= '0;
        end else begin
            grant_o       <= grant_d;
            grant_fu_o    <= grant_fu_d;
            fu_start_o    <= start_d;
            fu_port_sel_o <= sel_d;
        end
    end

endmodule
